// File: rtl/snoop_responder.sv
// Snoop responder for a 4-line direct-mapped cache: answers bus snoops,
// issues write-backs for exclusive lines and accepts local line writes.
module snoop_responder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bus_valid,
    input  logic [8:0] bus_in,
    output logic       bus_stall,
    output logic       wb_valid,
    input  logic       wb_ready,
    output logic [2:0] wb_addr,
    output logic [3:0] wb_data,
    input  logic       loc_we,
    input  logic [2:0] loc_addr,
    input  logic [1:0] loc_state,
    input  logic [3:0] loc_data,
    output logic       loc_ack,
    output logic       hit,
    output logic       err,
    input  logic [1:0] dbg_index,
    output logic [6:0] dbg_line
);

    localparam logic [1:0] ST_INVALID   = 2'b00;
    localparam logic [1:0] ST_EXCLUSIVE = 2'b01;
    localparam logic [1:0] ST_SHARED    = 2'b10;

    localparam logic [1:0] MSG_READ_MISS  = 2'b00;
    localparam logic [1:0] MSG_WRITE_MISS = 2'b01;
    localparam logic [1:0] MSG_INVALIDATE = 2'b10;
    localparam logic [1:0] MSG_EMPTY      = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WB   = 1'b1
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] line_state_q [4];
    logic [1:0] line_state_d [4];
    logic [3:0] line_tag_q, line_tag_d;
    logic [3:0] line_data_q [4];
    logic [3:0] line_data_d [4];
    logic       wb_valid_q, wb_valid_d;
    logic [2:0] wb_addr_q, wb_addr_d;
    logic [3:0] wb_data_q, wb_data_d;
    logic       hit_q, hit_d;
    logic       loc_ack_q, loc_ack_d;
    logic       err_q, err_d;

    logic [1:0] snp_msg_s;
    logic [2:0] snp_addr_s;
    logic [1:0] snp_idx_s;
    logic       snp_accept_s;
    logic       snp_match_s;
    logic       snp_hit_s;
    logic       snp_excl_s;
    logic       bus_data_unused_s;

    assign snp_msg_s    = bus_in[8:7];
    assign snp_addr_s   = bus_in[6:4];
    assign snp_idx_s    = snp_addr_s[1:0];
    assign bus_data_unused_s = ^bus_in[3:0];

    // Decode the snooped transaction against the addressed line.
    always_comb begin
        snp_accept_s = (fsm_q == IDLE) && bus_valid;
        snp_excl_s   = (line_state_q[snp_idx_s] == ST_EXCLUSIVE);
        snp_match_s  = ((line_state_q[snp_idx_s] == ST_EXCLUSIVE) ||
                        (line_state_q[snp_idx_s] == ST_SHARED)) &&
                       (line_tag_q[snp_idx_s] == snp_addr_s[2]);
        snp_hit_s    = snp_accept_s && snp_match_s && (snp_msg_s != MSG_EMPTY);
    end

    // Line storage update: local write first, then the snoop outcome; a
    // snoop hit on the same index suppresses the local write entirely.
    always_comb begin
        line_state_d = line_state_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        loc_ack_d    = 1'b0;
        err_d        = err_q;
        hit_d        = snp_hit_s;

        if (loc_we && !(snp_hit_s && (loc_addr[1:0] == snp_idx_s))) begin
            line_state_d[loc_addr[1:0]] = loc_state;
            line_tag_d[loc_addr[1:0]]   = loc_addr[2];
            line_data_d[loc_addr[1:0]]  = loc_data;
            loc_ack_d                   = 1'b1;
        end else begin
            loc_ack_d = 1'b0;
        end

        if (snp_hit_s) begin
            case (snp_msg_s)
                MSG_READ_MISS: begin
                    if (snp_excl_s) begin
                        line_state_d[snp_idx_s] = ST_SHARED;
                    end else begin
                        line_state_d[snp_idx_s] = line_state_q[snp_idx_s];
                    end
                end
                MSG_WRITE_MISS: begin
                    line_state_d[snp_idx_s] = ST_INVALID;
                end
                MSG_INVALIDATE: begin
                    line_state_d[snp_idx_s] = ST_INVALID;
                    if (snp_excl_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                default: begin
                    line_state_d[snp_idx_s] = line_state_q[snp_idx_s];
                end
            endcase
        end else begin
            line_state_d[snp_idx_s] = line_state_d[snp_idx_s];
        end
    end

    // Write-back FSM: an exclusive read/write-miss hit captures the line
    // before its state update and holds the request until memory accepts.
    always_comb begin
        fsm_d      = fsm_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        case (fsm_q)
            IDLE: begin
                if (snp_hit_s && snp_excl_s &&
                    ((snp_msg_s == MSG_READ_MISS) || (snp_msg_s == MSG_WRITE_MISS))) begin
                    fsm_d      = WB;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = snp_addr_s;
                    wb_data_d  = line_data_q[snp_idx_s];
                end else begin
                    fsm_d = IDLE;
                end
            end
            WB: begin
                if (wb_ready && wb_valid_q) begin
                    fsm_d      = IDLE;
                    wb_valid_d = 1'b0;
                end else begin
                    fsm_d = WB;
                end
            end
            default: begin
                fsm_d      = IDLE;
                wb_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            line_tag_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                line_state_q[i] <= ST_INVALID;
                line_data_q[i]  <= 4'b0000;
            end
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 3'b000;
            wb_data_q  <= 4'b0000;
            hit_q      <= 1'b0;
            loc_ack_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            line_tag_q   <= line_tag_d;
            line_state_q <= line_state_d;
            line_data_q  <= line_data_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            hit_q        <= hit_d;
            loc_ack_q    <= loc_ack_d;
            err_q        <= err_d;
        end
    end

    assign bus_stall = (fsm_q == WB);
    assign wb_valid  = wb_valid_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign hit       = hit_q;
    assign loc_ack   = loc_ack_q;
    assign err       = err_q;
    assign dbg_line  = {line_state_q[dbg_index], line_tag_q[dbg_index], line_data_q[dbg_index]};

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed scenarios followed by
// randomized traffic, all compared against a rule-level cache model.
module tb_snoop_responder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       bus_valid;
    logic [8:0] bus_in;
    logic       bus_stall;
    logic       wb_valid;
    logic       wb_ready;
    logic [2:0] wb_addr;
    logic [3:0] wb_data;
    logic       loc_we;
    logic [2:0] loc_addr;
    logic [1:0] loc_state;
    logic [3:0] loc_data;
    logic       loc_ack;
    logic       hit;
    logic       err;
    logic [1:0] dbg_index;
    logic [6:0] dbg_line;

    snoop_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_valid (bus_valid),
        .bus_in    (bus_in),
        .bus_stall (bus_stall),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_state (loc_state),
        .loc_data  (loc_data),
        .loc_ack   (loc_ack),
        .hit       (hit),
        .err       (err),
        .dbg_index (dbg_index),
        .dbg_line  (dbg_line)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: line contents plus the observable flags.
    int m_state [4];
    int m_tag   [4];
    int m_data  [4];
    bit m_busy, m_wbv, m_hit, m_ack, m_err;
    int m_wba, m_wbd;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 0;
            m_tag[i]   = 0;
            m_data[i]  = 0;
        end
        m_busy = 1'b0; m_wbv = 1'b0; m_hit = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        m_wba = 0; m_wbd = 0;
    endtask

    // Apply the protocol rules for the edge about to happen.
    task automatic model_step();
        int  msg, a, i, li, old_state, old_data;
        bit  accepted, snoop_hit, local_ok, owner;
        if (!reset_n) begin
            model_reset();
            return;
        end
        msg       = int'(bus_in[8:7]);
        a         = int'(bus_in[6:4]);
        i         = a % 4;
        li        = int'(loc_addr) % 4;
        old_state = m_state[i];
        old_data  = m_data[i];
        owner     = (old_state == 1);
        accepted  = !m_busy && bus_valid;
        snoop_hit = accepted && (msg != 3) && (old_state == 1 || old_state == 2) && (m_tag[i] == a / 4);
        local_ok  = loc_we && !(snoop_hit && li == i);

        if (m_busy && wb_ready) begin
            m_busy = 1'b0;
            m_wbv  = 1'b0;
        end
        if (local_ok) begin
            m_state[li] = int'(loc_state);
            m_tag[li]   = int'(loc_addr) / 4;
            m_data[li]  = int'(loc_data);
        end
        if (snoop_hit) begin
            if (msg == 0) m_state[i] = owner ? 2 : old_state;
            else          m_state[i] = 0;
            if (msg == 2 && owner) m_err = 1'b1;
            if (msg != 2 && owner) begin
                m_busy = 1'b1;
                m_wbv  = 1'b1;
                m_wba  = a;
                m_wbd  = old_data;
            end
        end
        m_hit = snoop_hit;
        m_ack = local_ok;
    endtask

    task automatic check_all();
        check_value("bus_stall", bus_stall, m_busy);
        check_value("wb_valid", wb_valid, m_wbv);
        check_value("wb_addr", wb_addr, m_wba);
        check_value("wb_data", wb_data, m_wbd);
        check_value("hit", hit, m_hit);
        check_value("loc_ack", loc_ack, m_ack);
        check_value("err", err, m_err);
        for (int i = 0; i < 4; i++) begin
            dbg_index = 2'(i);
            #1;
            check_value($sformatf("dbg_line%0d", i), dbg_line, m_state[i] * 32 + m_tag[i] * 16 + m_data[i]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic quiet();
        bus_valid = 1'b0;
        loc_we    = 1'b0;
        wb_ready  = 1'b0;
    endtask

    task automatic local_write(input logic [2:0] a, input logic [1:0] s, input logic [3:0] d);
        quiet();
        loc_we = 1'b1; loc_addr = a; loc_state = s; loc_data = d;
        cycle();
        loc_we = 1'b0;
    endtask

    task automatic snoop(input logic [1:0] msg, input logic [2:0] a);
        bus_valid = 1'b1;
        bus_in    = {msg, a, 4'(a)};
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus_in = 9'd0; loc_addr = 3'd0; loc_state = 2'd0; loc_data = 4'd0; dbg_index = 2'd0;
        quiet();
        model_reset();
        #1;
        check_all();
        cycle();
        reset_n = 1'b1;
        cycle();

        // Exclusive line read-missed: write-back of the old data.
        local_write(3'b101, 2'b01, 4'hA);
        snoop(2'b00, 3'b101);
        cycle();
        check_value("rm_hit", hit, 1'b1);
        check_value("rm_wb_addr", wb_addr, 3'b101);
        check_value("rm_wb_data", wb_data, 4'hA);
        dbg_index = 2'd1; #1;
        check_value("rm_line1", dbg_line, 7'b10_1_1010);
        quiet();
        cycle();
        cycle();
        wb_ready = 1'b1;
        cycle();
        check_value("rm_idle", bus_stall, 1'b0);
        quiet();

        // Shared line write-missed: invalidated, no write-back.
        local_write(3'b010, 2'b10, 4'h3);
        snoop(2'b01, 3'b010);
        cycle();
        check_value("wm_hit", hit, 1'b1);
        check_value("wm_stall", bus_stall, 1'b0);
        quiet();
        cycle();

        // Invalidate on an exclusive owner: tag mismatch first, then the error.
        local_write(3'b111, 2'b01, 4'h5);
        snoop(2'b10, 3'b011);
        cycle();
        check_value("inv_miss_hit", hit, 1'b0);
        snoop(2'b10, 3'b111);
        cycle();
        check_value("inv_err", err, 1'b1);
        quiet();
        cycle();
        cycle();
        check_value("inv_err_sticky", err, 1'b1);

        // Stalled write-back ignores further snoops until memory accepts.
        local_write(3'b101, 2'b01, 4'h6);
        local_write(3'b010, 2'b01, 4'h9);
        snoop(2'b00, 3'b101);
        cycle();
        snoop(2'b00, 3'b010);
        for (int k = 0; k < 5; k++) cycle();
        check_value("stall_wb_addr", wb_addr, 3'b101);
        wb_ready = 1'b1;
        cycle();
        wb_ready = 1'b0;
        cycle();
        check_value("b2b_wb_addr", wb_addr, 3'b010);
        wb_ready = 1'b1;
        bus_valid = 1'b0;
        cycle();
        quiet();

        // Local write colliding with a snoop: same index loses, other index wins.
        local_write(3'b000, 2'b10, 4'h1);
        snoop(2'b01, 3'b000);
        loc_we = 1'b1; loc_addr = 3'b100; loc_state = 2'b01; loc_data = 4'hF;
        cycle();
        check_value("coll_ack", loc_ack, 1'b0);
        local_write(3'b000, 2'b10, 4'h1);
        snoop(2'b01, 3'b000);
        loc_we = 1'b1; loc_addr = 3'b001; loc_state = 2'b10; loc_data = 4'h7;
        cycle();
        check_value("par_ack", loc_ack, 1'b1);
        quiet();

        // Reset in the middle of a write-back.
        local_write(3'b101, 2'b01, 4'hC);
        snoop(2'b00, 3'b101);
        cycle();
        quiet();
        reset_pulse();
        cycle();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bus_valid = ($urandom_range(0, 99) < 60);
            bus_in    = 9'($urandom);
            loc_we    = ($urandom_range(0, 99) < 40);
            loc_addr  = 3'($urandom);
            loc_state = 2'($urandom);
            loc_data  = 4'($urandom);
            wb_ready  = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 199) == 0) reset_pulse();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
